// File: rtl/reg_load_arb_pkg.sv
// reg_load_arb_pkg
//   Shared types and width helpers for the register-load arbiter slice.
//   - state_t : arbiter FSM states (normal arbitration / bank clear sequence)
//   - idx_w() : bit width needed to index n items (minimum 1 bit)
package reg_load_arb_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Width of an index that addresses n items; never returns 0 so that
    // single-entry configurations still get a legal vector.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin pick: the first asserted request at or after
//   ptr (wrapping past NREQ-1 back to 0) wins.
// Ports
//   req       in  NREQ  request vector (already qualified by the caller)
//   ptr       in  IW    highest-priority requester index (must be < NREQ)
//   grant     out NREQ  one-hot grant, all zero when no request
//   grant_idx out IW    encoded index of the granted requester
//   grant_any out 1     any request granted
module rr_arbiter
    import reg_load_arb_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx,
    output logic            grant_any
);

    always_comb begin
        int idx;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = 0;
        // Walk from the farthest offset down to ptr itself so the candidate
        // closest to ptr overwrites any earlier hit and ends up the winner.
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = IW'(idx);
                grant_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_load_arbiter.sv
// reg_load_arbiter
//   Shares one bank of load-enabled registers between NREQ write requesters.
//   One write per cycle is granted round-robin and presented to the bank as a
//   registered one-hot load vector plus shared data. A clear request runs a
//   CLR_CYCLES-long bank reset during which all writes stall.
//
//   Handshake: a requester transfers on a rising edge where req_valid[i] and
//   req_ready[i] are both high. req_ready is combinational, at most one bit is
//   set, and it is only ever set for a requester whose req_valid is high; a
//   requester must hold addr/data stable while valid and not yet ready.
//
//   Optional feature macro: REG_LOAD_ARB_WRITE_PROTECT_EN adds input wp_mask;
//   accepted writes to protected registers are dropped like bad addresses.
//
// Ports
//   clk, reset  clock and synchronous active-high reset
//   req_valid   in  NREQ        write requests
//   req_ready   out NREQ        one-hot accept (combinational)
//   req_addr    in  NREQ*AW     register index per requester
//   req_data    in  NREQ*WIDTH  write data per requester
//   clear_req   in  1           level request to clear the bank
//   wp_mask     in  NREG        write-protect bits (feature macro only)
//   clear_ack   out 1           pulse in the final clear cycle
//   reg_load    out NREG        registered one-hot load enables
//   reg_in      out WIDTH       registered shared write data
//   reg_reset   out 1           registered bank clear
//   addr_err    out 1           registered pulse: accepted write dropped
//   busy        out 1           FSM is in the clear sequence
module reg_load_arbiter
    import reg_load_arb_pkg::*;
#(
    parameter  int NREQ       = 4,
    parameter  int NREG       = 8,
    parameter  int WIDTH      = 8,
    parameter  int CLR_CYCLES = 2,
    localparam int AW         = idx_w(NREG)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*AW-1:0]    req_addr,
    input  logic [NREQ*WIDTH-1:0] req_data,
    input  logic                  clear_req,
`ifdef REG_LOAD_ARB_WRITE_PROTECT_EN
    input  logic [NREG-1:0]       wp_mask,
`endif
    output logic                  clear_ack,
    output logic [NREG-1:0]       reg_load,
    output logic [WIDTH-1:0]      reg_in,
    output logic                  reg_reset,
    output logic                  addr_err,
    output logic                  busy
);

    localparam int IW = idx_w(NREQ);
    localparam int CW = idx_w(CLR_CYCLES);

    state_t          state, state_nxt;
    logic [IW-1:0]   rr_ptr, rr_ptr_nxt;
    logic [CW-1:0]   clr_cnt, clr_cnt_nxt;

    logic            arb_en;
    logic [NREQ-1:0] grant;
    logic [IW-1:0]   grant_idx;
    logic            grant_any;
    logic [AW-1:0]   sel_addr;
    logic [WIDTH-1:0] sel_data;
    logic [NREG-1:0] load_dec;

    // A pending clear blocks arbitration in the same cycle it is seen.
    assign arb_en = (state == ST_RUN) && !clear_req;

    rr_arbiter #(
        .NREQ(NREQ)
    ) u_rr (
        .req       (req_valid & {NREQ{arb_en}}),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign req_ready = grant;
    assign sel_addr  = req_addr[int'(grant_idx)*AW +: AW];
    assign sel_data  = req_data[int'(grant_idx)*WIDTH +: WIDTH];
    assign busy      = (state == ST_CLEAR);
    assign clear_ack = (state == ST_CLEAR) && (clr_cnt == '0);

    // Address decode. Out-of-range indices match no bit, so an all-zero
    // result is exactly the "write dropped" condition.
    always_comb begin
        load_dec = '0;
        for (int r = 0; r < NREG; r++) begin
            if (int'(sel_addr) == r) load_dec[r] = 1'b1;
        end
`ifdef REG_LOAD_ARB_WRITE_PROTECT_EN
        load_dec = load_dec & ~wp_mask;
`endif
    end

    // Next-state: FSM, clear down-counter and round-robin pointer.
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        rr_ptr_nxt  = rr_ptr;
        case (state)
            ST_RUN: begin
                if (clear_req) begin
                    state_nxt   = ST_CLEAR;
                    clr_cnt_nxt = CW'(CLR_CYCLES - 1);
                end else if (grant_any) begin
                    rr_ptr_nxt = (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
                end
            end
            ST_CLEAR: begin
                if (clr_cnt == '0) state_nxt = ST_RUN;
                else               clr_cnt_nxt = clr_cnt - 1'b1;
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_RUN;
            clr_cnt   <= '0;
            rr_ptr    <= '0;
            reg_load  <= '0;
            reg_in    <= '0;
            reg_reset <= 1'b0;
            addr_err  <= 1'b0;
        end else begin
            state     <= state_nxt;
            clr_cnt   <= clr_cnt_nxt;
            rr_ptr    <= rr_ptr_nxt;
            reg_load  <= grant_any ? load_dec : '0;
            addr_err  <= grant_any && (load_dec == '0);
            if (grant_any) reg_in <= sel_data;
            // High for every cycle spent in the clear sequence.
            reg_reset <= (state_nxt == ST_CLEAR);
        end
    end

endmodule

// File: tb/tb_reg_load_arbiter.sv
module tb_reg_load_arbiter;

    localparam int NREQ       = 4;
    localparam int NREG       = 8;
    localparam int NREG6      = 6;
    localparam int WIDTH      = 8;
    localparam int CLR_CYCLES = 2;
    localparam int AW         = 3;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*AW-1:0]    req_addr;
    logic [NREQ*WIDTH-1:0] req_data;
    logic                  clear_req;

    logic [NREQ-1:0]  req_ready, ready6;
    logic             clear_ack, ack6, reg_reset, rst6, addr_err, err6, busy, busy6;
    logic [NREG-1:0]  reg_load;
    logic [NREG6-1:0] load6;
    logic [WIDTH-1:0] reg_in, in6;
`ifdef REG_LOAD_ARB_WRITE_PROTECT_EN
    logic [NREG-1:0]  wp_mask;
    logic [NREG6-1:0] wp_mask6;
`endif

    // clock / reset
    always #5 clk = ~clk;

    reg_load_arbiter #(.NREQ(NREQ), .NREG(NREG), .WIDTH(WIDTH), .CLR_CYCLES(CLR_CYCLES)) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .clear_req(clear_req),
`ifdef REG_LOAD_ARB_WRITE_PROTECT_EN
        .wp_mask(wp_mask),
`endif
        .clear_ack(clear_ack), .reg_load(reg_load), .reg_in(reg_in),
        .reg_reset(reg_reset), .addr_err(addr_err), .busy(busy)
    );

    // Second instance with a non-power-of-two bank, driven by the same inputs.
    reg_load_arbiter #(.NREQ(NREQ), .NREG(NREG6), .WIDTH(WIDTH), .CLR_CYCLES(CLR_CYCLES)) u_dut6 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready6),
        .req_addr(req_addr), .req_data(req_data), .clear_req(clear_req),
`ifdef REG_LOAD_ARB_WRITE_PROTECT_EN
        .wp_mask(wp_mask6),
`endif
        .clear_ack(ack6), .reg_load(load6), .reg_in(in6),
        .reg_reset(rst6), .addr_err(err6), .busy(busy6)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state: pointer and clear cycles remaining.
    int               m_ptr      = 0;
    int               m_clr_left = 0;
    int               m_gnt;
    logic [NREQ-1:0]  exp_ready;
    logic             exp_busy, exp_ack, exp_err, exp_err6, exp_rst;
    logic [NREG-1:0]  exp_load;
    logic [NREG6-1:0] exp_load6;
    logic [WIDTH-1:0] exp_in;
    logic [NREQ-1:0]  obs_ready;
    logic             obs_busy, obs_ack;
    logic [5:0]       obs6;

    // One clock cycle: sample combinational outputs before the edge, advance
    // the model at the edge, return 1 time unit after it.
    task automatic tick();
        int  a;
        logic wp;
        #3;
        m_gnt = -1;
        if (m_clr_left == 0 && !clear_req) begin
            for (int k = 0; k < NREQ; k++) begin
                if (m_gnt < 0 && req_valid[(m_ptr + k) % NREQ]) m_gnt = (m_ptr + k) % NREQ;
            end
        end
        exp_ready = (m_gnt >= 0) ? NREQ'(1 << m_gnt) : '0;
        exp_busy  = (m_clr_left != 0);
        exp_ack   = (m_clr_left == 1);
        obs_ready = req_ready;
        obs_busy  = busy;
        obs_ack   = clear_ack;
        obs6      = {ready6, busy6, ack6};
        @(posedge clk);
        exp_load  = '0;
        exp_load6 = '0;
        exp_err   = 1'b0;
        exp_err6  = 1'b0;
        if (reset) begin
            m_ptr = 0; m_clr_left = 0; exp_in = '0; exp_rst = 1'b0;
        end else if (m_clr_left != 0) begin
            m_clr_left = m_clr_left - 1;
            exp_rst    = (m_clr_left != 0);
        end else if (clear_req) begin
            m_clr_left = CLR_CYCLES;
            exp_rst    = 1'b1;
        end else begin
            exp_rst = 1'b0;
            if (m_gnt >= 0) begin
                a      = int'(req_addr[m_gnt*AW +: AW]);
                exp_in = req_data[m_gnt*WIDTH +: WIDTH];
                wp     = 1'b0;
`ifdef REG_LOAD_ARB_WRITE_PROTECT_EN
                if (a < NREG) wp = wp_mask[a];
`endif
                if (a < NREG && !wp) exp_load = NREG'(1 << a);
                else                 exp_err  = 1'b1;
                if (a < NREG6) exp_load6 = NREG6'(1 << a);
                else           exp_err6  = 1'b1;
                m_ptr = (m_gnt + 1) % NREQ;
            end
        end
        #1;
    endtask

    task automatic set_req(input int i, input int addr, input logic [WIDTH-1:0] data);
        req_addr[i*AW +: AW]       = AW'(addr);
        req_data[i*WIDTH +: WIDTH] = data;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = '0; req_addr = '0; req_data = '0; clear_req = 1'b0;
`ifdef REG_LOAD_ARB_WRITE_PROTECT_EN
        wp_mask = '0; wp_mask6 = '0;
`endif
        tick(); tick();
        checks++;
        if ({reg_load, reg_in, addr_err, reg_reset, busy, clear_ack, load6, err6} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got load=%h in=%h err=%b rst=%b busy=%b ack=%b exp all 0",
                     reg_load, reg_in, addr_err, reg_reset, busy, clear_ack);
        end
        reset = 1'b0;
        repeat (2) begin
            tick();
            checks++;
            if ({obs_ready, obs_busy, obs_ack} !== 6'b0) begin
                failures++;
                $display("FAIL reset_idle comb got=%h exp=0", {obs_ready, obs_busy, obs_ack});
            end
            checks++;
            if ({reg_load, reg_in, addr_err, reg_reset} !== {exp_load, exp_in, exp_err, exp_rst}) begin
                failures++;
                $display("FAIL reset_idle bank got=%h exp=%h", {reg_load, reg_in, addr_err, reg_reset}, {exp_load, exp_in, exp_err, exp_rst});
            end
        end
    endtask

    task automatic test_rr_all();
        req_valid = 4'b1111;
        for (int i = 0; i < NREQ; i++) set_req(i, i, 8'hA0 + 8'(i));
        for (int i = 0; i < NREQ; i++) begin
            tick();
            checks++;
            if (obs_ready !== 4'(1 << i) || reg_load !== 8'(1 << i) || reg_in !== 8'hA0 + 8'(i)) begin
                failures++;
                $display("FAIL rr_all step%0d got ready=%b load=%h in=%h exp ready=%b load=%h in=%h",
                         i, obs_ready, reg_load, reg_in, 4'(1 << i), 8'(1 << i), 8'hA0 + 8'(i));
            end
            checks++;
            if ({obs_ready, obs_busy, obs_ack, reg_load, reg_in, addr_err, reg_reset} !==
                {exp_ready, exp_busy, exp_ack, exp_load, exp_in, exp_err, exp_rst}) begin
                failures++;
                $display("FAIL rr_all model got=%h exp=%h", {obs_ready, obs_busy, obs_ack, reg_load, reg_in, addr_err, reg_reset},
                         {exp_ready, exp_busy, exp_ack, exp_load, exp_in, exp_err, exp_rst});
            end
        end
    endtask

    task automatic test_sparse_wrap();
        int seq[3] = '{1, 3, 1};
        req_valid = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs_ready !== 4'(1 << seq[i]) || reg_load !== 8'(1 << seq[i])) begin
                failures++;
                $display("FAIL sparse_wrap step%0d got ready=%b load=%h exp ready=%b load=%h",
                         i, obs_ready, reg_load, 4'(1 << seq[i]), 8'(1 << seq[i]));
            end
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_addr_decode();
        int addrs[4] = '{7, 6, 5, 6};
        logic [7:0] datas[4] = '{8'h5A, 8'h3C, 8'hC3, 8'h11};
        logic [7:0] el8[4] = '{8'h80, 8'h40, 8'h20, 8'h40};
        logic [5:0] el6[4] = '{6'h00, 6'h00, 6'h20, 6'h00};
        logic       ee6[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        req_valid = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            set_req(0, addrs[i], datas[i]);
            tick();
            checks++;
            if (reg_load !== el8[i] || reg_in !== datas[i] || addr_err !== 1'b0 || load6 !== el6[i] || err6 !== ee6[i]) begin
                failures++;
                $display("FAIL addr_decode addr=%0d got load=%h in=%h err=%b load6=%h err6=%b exp load=%h in=%h err=0 load6=%h err6=%b",
                         addrs[i], reg_load, reg_in, addr_err, load6, err6, el8[i], datas[i], el6[i], ee6[i]);
            end
            checks++;
            if ({load6, in6, err6, rst6, obs6} !== {exp_load6, exp_in, exp_err6, exp_rst, exp_ready, exp_busy, exp_ack}) begin
                failures++;
                $display("FAIL addr_decode nreg6 model got=%h exp=%h", {load6, in6, err6, rst6, obs6},
                         {exp_load6, exp_in, exp_err6, exp_rst, exp_ready, exp_busy, exp_ack});
            end
        end
        req_valid = '0;
        tick();
        checks++;
        if (err6 !== 1'b0 || load6 !== 6'h0 || reg_load !== 8'h0 || reg_in !== 8'h11) begin
            failures++;
            $display("FAIL addr_decode idle got err6=%b load6=%h load=%h in=%h exp 0,0,0,11", err6, load6, reg_load, reg_in);
        end
    endtask

    task automatic test_clear();
        logic [5:0] busy_seq;
        // Clear and a write arrive together: clear wins.
        req_valid = 4'b0001; set_req(0, 2, 8'h99); clear_req = 1'b1;
        tick();
        checks++;
        if (obs_ready !== 4'b0 || reg_reset !== 1'b1 || reg_load !== 8'h0) begin
            failures++;
            $display("FAIL clear_entry got ready=%b rst=%b load=%h exp ready=0 rst=1 load=0", obs_ready, reg_reset, reg_load);
        end
        clear_req = 1'b0;
        tick();
        checks++;
        if ({obs_ready, obs_busy, obs_ack, reg_reset} !== {4'b0, 1'b1, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL clear_cycle1 got ready=%b busy=%b ack=%b rst=%b exp 0000,1,0,1", obs_ready, obs_busy, obs_ack, reg_reset);
        end
        tick();
        checks++;
        if ({obs_ready, obs_busy, obs_ack, reg_reset} !== {4'b0, 1'b1, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL clear_cycle2 got ready=%b busy=%b ack=%b rst=%b exp 0000,1,1,0", obs_ready, obs_busy, obs_ack, reg_reset);
        end
        tick();
        checks++;
        if (obs_ready !== 4'b0001 || obs_busy !== 1'b0 || reg_load !== 8'h04 || reg_in !== 8'h99) begin
            failures++;
            $display("FAIL clear_resume got ready=%b busy=%b load=%h in=%h exp 0001,0,04,99", obs_ready, obs_busy, reg_load, reg_in);
        end
        // Held clear: one run cycle between back-to-back clears.
        clear_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            busy_seq[i] = obs_busy;
            checks++;
            if ({obs_ready, obs_busy, obs_ack, reg_load, reg_in, addr_err, reg_reset} !==
                {exp_ready, exp_busy, exp_ack, exp_load, exp_in, exp_err, exp_rst}) begin
                failures++;
                $display("FAIL clear_held model got=%h exp=%h", {obs_ready, obs_busy, obs_ack, reg_load, reg_in, addr_err, reg_reset},
                         {exp_ready, exp_busy, exp_ack, exp_load, exp_in, exp_err, exp_rst});
            end
        end
        checks++;
        if (busy_seq !== 6'b110110) begin
            failures++;
            $display("FAIL clear_held busy pattern got=%b exp=110110 (lsb first cycle)", busy_seq);
        end
        clear_req = 1'b0; req_valid = '0;
        tick();
    endtask

    task automatic test_reset_mid_clear();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0; reset = 1'b1;
        tick();
        checks++;
        if (obs_busy !== 1'b1 || obs_ack !== 1'b0 || reg_reset !== 1'b0 || busy !== 1'b0 || clear_ack !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_clear got pre_busy=%b pre_ack=%b rst=%b busy=%b ack=%b exp 1,0,0,0,0",
                     obs_busy, obs_ack, reg_reset, busy, clear_ack);
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({obs_busy, obs_ack, reg_reset, busy, clear_ack} !== 5'b0) begin
            failures++;
            $display("FAIL reset_mid_clear after got busy=%b ack=%b rst=%b exp 0,0,0", obs_busy, obs_ack, reg_reset);
        end
`ifdef REG_LOAD_ARB_WRITE_PROTECT_EN
        wp_mask = 8'h01; req_valid = 4'b0001; set_req(0, 0, 8'h77);
        tick();
        checks++;
        if (reg_load !== 8'h00 || addr_err !== 1'b1 || load6 !== 6'h01 || err6 !== 1'b0) begin
            failures++;
            $display("FAIL write_protect got load=%h err=%b load6=%h err6=%b exp 00,1,01,0", reg_load, addr_err, load6, err6);
        end
        set_req(0, 1, 8'h78);
        tick();
        checks++;
        if (reg_load !== 8'h02 || addr_err !== 1'b0) begin
            failures++;
            $display("FAIL write_protect_unmasked got load=%h err=%b exp 02,0", reg_load, addr_err);
        end
        wp_mask = '0; req_valid = '0;
        tick();
`endif
    endtask

    task automatic test_back_to_back();
        req_valid = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            set_req(2, $urandom_range(0, NREG - 1), 8'($urandom));
            tick();
            checks++;
            if (obs_ready !== 4'b0100 || {reg_load, reg_in, addr_err} !== {exp_load, exp_in, exp_err}) begin
                failures++;
                $display("FAIL back_to_back step%0d got ready=%b load=%h in=%h err=%b exp ready=0100 load=%h in=%h err=%b",
                         i, obs_ready, reg_load, reg_in, addr_err, exp_load, exp_in, exp_err);
            end
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            req_valid = NREQ'($urandom_range(0, 15));
            req_addr  = (NREQ*AW)'($urandom);
            req_data  = $urandom;
            if ($urandom_range(0, 7) == 0) clear_req = ~clear_req;
            reset = ($urandom_range(0, 99) == 0);
`ifdef REG_LOAD_ARB_WRITE_PROTECT_EN
            wp_mask = 8'($urandom & $urandom & $urandom);
`endif
            tick();
            checks++;
            if ({obs_ready, obs_busy, obs_ack, reg_load, reg_in, addr_err, reg_reset} !==
                {exp_ready, exp_busy, exp_ack, exp_load, exp_in, exp_err, exp_rst}) begin
                failures++;
                $display("FAIL random cyc%0d got=%h exp=%h", n, {obs_ready, obs_busy, obs_ack, reg_load, reg_in, addr_err, reg_reset},
                         {exp_ready, exp_busy, exp_ack, exp_load, exp_in, exp_err, exp_rst});
            end
            checks++;
            if ({load6, in6, err6, rst6, obs6} !== {exp_load6, exp_in, exp_err6, exp_rst, exp_ready, exp_busy, exp_ack}) begin
                failures++;
                $display("FAIL random_nreg6 cyc%0d got=%h exp=%h", n, {load6, in6, err6, rst6, obs6},
                         {exp_load6, exp_in, exp_err6, exp_rst, exp_ready, exp_busy, exp_ack});
            end
        end
        reset = 1'b0; clear_req = 1'b0; req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_rr_all();
        test_sparse_wrap();
        test_addr_decode();
        test_clear();
        test_reset_mid_clear();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
